// File: rtl/lcd_bus_timer.sv
// HD44780-style LCD write-only bus timer: runs the power-up init sequence, then
// accepts bytes over a valid/ready handshake and strobes them onto the panel bus.
module lcd_bus_timer #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned PULSE_CYC  = 4,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned CMD_WAIT   = 40,
    parameter int unsigned CLEAR_WAIT = 160,
    parameter int unsigned POWER_WAIT = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_rs,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] lcd_db,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       init_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_LOAD,
        SETUP,
        PULSE,
        HOLD,
        SETTLE,
        IDLE
    } state_t;

    localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
    localparam logic [15:0] PULSE_LD = 16'(PULSE_CYC - 1);
    localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);
    localparam logic [15:0] CMD_LD   = 16'(CMD_WAIT - 1);
    localparam logic [15:0] CLEAR_LD = 16'(CLEAR_WAIT - 1);

    // The counter is cleared by reset and counts down through wraparound, so the
    // power-up wait ends at a negative terminal value; INIT_LOAD supplies the last cycle.
    localparam int unsigned PWR_STAY = (POWER_WAIT > 1) ? POWER_WAIT - 2 : 0;
    localparam logic [15:0] PWR_TERM = 16'd0 - 16'(PWR_STAY);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  init_idx_q, init_idx_d;
    logic [7:0]  lcd_db_q, lcd_db_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic        lcd_e_q, lcd_e_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        init_done_q, init_done_d;
    logic        is_clear;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) need the long settle time.
    assign is_clear = !lcd_rs_q && (lcd_db_q == 8'h01 || lcd_db_q == 8'h02 || lcd_db_q == 8'h03);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        lcd_db_d    = lcd_db_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_e_d     = lcd_e_q;
        in_ready_d  = in_ready_q;
        init_done_d = init_done_q;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == PWR_TERM) begin
                    state_d = INIT_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            INIT_LOAD: begin
                init_idx_d = 2'd0;
                lcd_db_d   = init_byte(2'd0);
                lcd_rs_d   = 1'b0;
                cnt_d      = SETUP_LD;
                state_d    = SETUP;
            end
            SETUP: begin
                if (cnt_q == 16'd0) begin
                    state_d = PULSE;
                    lcd_e_d = 1'b1;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            PULSE: begin
                if (cnt_q == 16'd0) begin
                    state_d = HOLD;
                    lcd_e_d = 1'b0;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 16'd0) begin
                    state_d = SETTLE;
                    cnt_d   = is_clear ? CLEAR_LD : CMD_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            SETTLE: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!init_done_q && init_idx_q != 2'd3) begin
                    init_idx_d = init_idx_q + 2'd1;
                    lcd_db_d   = init_byte(init_idx_q + 2'd1);
                    lcd_rs_d   = 1'b0;
                    cnt_d      = SETUP_LD;
                    state_d    = SETUP;
                end else begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                    in_ready_d  = 1'b1;
                end
            end
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    lcd_db_d   = in_data;
                    lcd_rs_d   = in_rs;
                    cnt_d      = SETUP_LD;
                    in_ready_d = 1'b0;
                    state_d    = SETUP;
                end
            end
            default: begin
                state_d = PWR_WAIT;
            end
        endcase

        busy_d = !in_ready_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= 16'd0;
            init_idx_q  <= 2'd0;
            lcd_db_q    <= 8'h00;
            lcd_rs_q    <= 1'b0;
            lcd_e_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            lcd_db_q    <= lcd_db_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_e_q     <= lcd_e_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
        end
    end

    assign lcd_db    = lcd_db_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = lcd_e_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_bus_timer.sv
// Directed bench for lcd_bus_timer: reset values, init sequence timing, a table of
// single writes with hand-computed busy lengths, a streamed pair, and mid-write reset.
module tb_lcd_bus_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] inData = 8'h00;
   logic       inRs = 1'b0;
   logic       inValid = 1'b0;
   logic       inReady;
   logic [7:0] lcdDb;
   logic       lcdRs;
   logic       lcdRw;
   logic       lcdE;
   logic       initDone;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int rwBad = 0;
   int busyBad = 0;

   typedef struct {
      logic [7:0] data;
      logic       rs;
      int         lowCycles;
   } vec_t;

   vec_t vecs[8];

   lcd_bus_timer dut (
      .clk(clk),
      .reset(reset),
      .in_data(inData),
      .in_rs(inRs),
      .in_valid(inValid),
      .in_ready(inReady),
      .lcd_db(lcdDb),
      .lcd_rs(lcdRs),
      .lcd_rw(lcdRw),
      .lcd_e(lcdE),
      .init_done(initDone),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Advance one edge and sample 1ns later; also tallies invariants checked at the end.
   task automatic tick();
      @(posedge clk);
      #1;
      if (lcdRw !== 1'b0) rwBad++;
      if (busy !== ~inReady) busyBad++;
   endtask

   task automatic applyStimulus(input logic [7:0] d, input logic r, input string tag);
      int n = 0;
      while (inReady !== 1'b1 && n < 500) begin
         tick();
         n++;
      end
      checkOutput({tag, "_ready_before"}, 32'(inReady), 32'd1);
      inData = d;
      inRs = r;
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
   endtask

   // Called right after the transfer edge N; sample k is taken after edge N+k.
   task automatic runWrite(input vec_t v, input string tag);
      int readyK = -1;
      int eBad = 0;
      int holdBad = 0;
      checkOutput({tag, "_db"}, 32'(lcdDb), 32'(v.data));
      checkOutput({tag, "_rs"}, 32'(lcdRs), 32'(v.rs));
      checkOutput({tag, "_ready_drop"}, 32'(inReady), 32'd0);
      for (int k = 0; k < 400; k++) begin
         if (k > 0) tick();
         if (inReady === 1'b1) begin
            readyK = k;
            break;
         end
         if (lcdDb !== v.data || lcdRs !== v.rs) holdBad++;
         if (lcdE !== ((k >= 2 && k <= 5) ? 1'b1 : 1'b0)) eBad++;
      end
      checkOutput({tag, "_low_cycles"}, 32'(readyK), 32'(v.lowCycles));
      checkOutput({tag, "_e_pattern_errs"}, 32'(eBad), 32'd0);
      checkOutput({tag, "_bus_hold_errs"}, 32'(holdBad), 32'd0);
   endtask

   // Releases reset and follows the init sequence until init_done rises.
   task automatic initCheck(input string tag);
      logic [7:0] pulseDb[4];
      logic       pulseRs[4];
      int         pulseW[4];
      int         nPulses = 0;
      int         width = 0;
      int         doneT = -1;
      logic       prevE = 1'b0;
      logic [7:0] expDb[4];
      expDb[0] = 8'h38;
      expDb[1] = 8'h0C;
      expDb[2] = 8'h06;
      expDb[3] = 8'h01;
      for (int i = 0; i < 4; i++) begin
         pulseDb[i] = 8'h00;
         pulseRs[i] = 1'b1;
         pulseW[i] = 0;
      end
      reset = 1'b1;
      for (int t = 1; t <= 1000; t++) begin
         tick();
         if (lcdE === 1'b1 && prevE === 1'b0) begin
            if (nPulses < 4) begin
               pulseDb[nPulses] = lcdDb;
               pulseRs[nPulses] = lcdRs;
            end
            width = 0;
         end
         if (lcdE === 1'b1) width++;
         if (lcdE === 1'b0 && prevE === 1'b1) begin
            if (nPulses < 4) pulseW[nPulses] = width;
            nPulses++;
         end
         prevE = lcdE;
         if (initDone === 1'b1) begin
            doneT = t;
            break;
         end
      end
      checkOutput({tag, "_done_cycle"}, 32'(doneT), 32'd412);
      checkOutput({tag, "_pulse_count"}, 32'(nPulses), 32'd4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("%s_byte%0d", tag, i), 32'(pulseDb[i]), 32'(expDb[i]));
         checkOutput($sformatf("%s_rs%0d", tag, i), 32'(pulseRs[i]), 32'd0);
         checkOutput($sformatf("%s_width%0d", tag, i), 32'(pulseW[i]), 32'd4);
      end
      checkOutput({tag, "_ready_at_done"}, 32'(inReady), 32'd1);
   endtask

   initial begin
      int accepts;
      int acceptT[2];
      int nPulse;
      logic [7:0] pulseDb[2];
      logic prevE;
      logic acc;
      int eHigh;

      vecs[0] = '{8'h41, 1'b1, 48};
      vecs[1] = '{8'h01, 1'b0, 168};
      vecs[2] = '{8'h80, 1'b0, 48};
      vecs[3] = '{8'h02, 1'b0, 168};
      vecs[4] = '{8'h03, 1'b0, 168};
      vecs[5] = '{8'h04, 1'b0, 48};
      vecs[6] = '{8'h01, 1'b1, 48};
      vecs[7] = '{8'h00, 1'b0, 48};

      // Reset held for three cycles: everything at its reset value, strobe never high.
      eHigh = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (lcdE !== 1'b0) eHigh++;
         checkOutput($sformatf("rst%0d_db", c), 32'(lcdDb), 32'h00);
         checkOutput($sformatf("rst%0d_rs", c), 32'(lcdRs), 32'd0);
         checkOutput($sformatf("rst%0d_ready", c), 32'(inReady), 32'd0);
         checkOutput($sformatf("rst%0d_busy", c), 32'(busy), 32'd1);
         checkOutput($sformatf("rst%0d_init_done", c), 32'(initDone), 32'd0);
      end
      checkOutput("rst_e_never_high", 32'(eHigh), 32'd0);

      initCheck("init");

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].data, vecs[i].rs, $sformatf("vec%0d", i));
         runWrite(vecs[i], $sformatf("vec%0d", i));
      end

      // Stream "HI" with valid held high; one idle cycle separates the 48-cycle writes.
      accepts = 0;
      nPulse = 0;
      prevE = 1'b0;
      acceptT[0] = -1;
      acceptT[1] = -1;
      pulseDb[0] = 8'h00;
      pulseDb[1] = 8'h00;
      inData = 8'h48;
      inRs = 1'b1;
      inValid = 1'b1;
      for (int t = 0; t < 250; t++) begin
         acc = inValid && inReady;
         tick();
         if (acc) begin
            if (accepts < 2) acceptT[accepts] = t;
            accepts++;
            if (accepts == 1) inData = 8'h49;
            if (accepts == 2) inValid = 1'b0;
         end
         if (lcdE === 1'b1 && prevE === 1'b0) begin
            if (nPulse < 2) pulseDb[nPulse] = lcdDb;
            nPulse++;
         end
         prevE = lcdE;
      end
      inValid = 1'b0;
      checkOutput("hi_accepts", 32'(accepts), 32'd2);
      checkOutput("hi_spacing", 32'(acceptT[1] - acceptT[0]), 32'd49);
      checkOutput("hi_pulses", 32'(nPulse), 32'd2);
      checkOutput("hi_first_byte", 32'(pulseDb[0]), 32'h48);
      checkOutput("hi_second_byte", 32'(pulseDb[1]), 32'h49);

      // Reset during the enable pulse of 0x41, then the full init must repeat.
      applyStimulus(8'h41, 1'b1, "midrst");
      tick();
      tick();
      tick();
      checkOutput("midrst_e_before", 32'(lcdE), 32'd1);
      reset = 1'b0;
      tick();
      checkOutput("midrst_e_after", 32'(lcdE), 32'd0);
      checkOutput("midrst_init_done", 32'(initDone), 32'd0);
      checkOutput("midrst_ready", 32'(inReady), 32'd0);
      checkOutput("midrst_db", 32'(lcdDb), 32'h00);
      initCheck("reinit");

      checkOutput("rw_tied_low_errs", 32'(rwBad), 32'd0);
      checkOutput("busy_not_ready_errs", 32'(busyBad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
